tx_char_scheduler: RTL

//  Transmit-side character scheduler for the SpaceWire link (ECSS-E-ST-50-12C).

---
 rtl/tx_sched_pkg.sv | 44 ++++
 rtl/tx_sched_pick.sv | 65 ++++++
 rtl/tx_char_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// ----------------------------------------------------------------------------
// tx_sched_pkg
//   Shared definitions for the SpaceWire transmit character scheduler:
//     - enc_type_e     : character codes presented to the TX encoder
//     - sched_state_e  : scheduler FSM states (IDLE / HOLD / GAP)
//     - LINK_*         : link_state codes coming from the link FSM
//     - CTRL_EOP/EEP   : control byte values carried with txdata bit8 = 1
//   Ports: none (package only).
// ----------------------------------------------------------------------------
package tx_sched_pkg;

    // Character codes on enc_type.
    typedef enum logic [2:0] {
        ENC_NULL  = 3'd0,
        ENC_FCT   = 3'd1,
        ENC_TIMEC = 3'd2,
        ENC_DATA  = 3'd3,
        ENC_EOP   = 3'd4,
        ENC_EEP   = 3'd5
    } enc_type_e;

    // Scheduler FSM. PICK is not a state: selection happens combinationally
    // while in IDLE and is captured on the IDLE -> HOLD edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    // link_state codes. Values 2 and 3 both mean RUN.
    localparam logic [1:0] LINK_STARTED    = 2'd0;
    localparam logic [1:0] LINK_CONNECTING = 2'd1;
    localparam logic [1:0] LINK_RUN        = 2'd2;

    // Control byte values of an N-Char with the control flag set.
    localparam logic [7:0] CTRL_EOP = 8'h00;
    localparam logic [7:0] CTRL_EEP = 8'h01;

    // N-Chars consume host data and TX credit; L-Chars (NULL/FCT/TIMEC) do not.
    function automatic logic is_nchar(input enc_type_e t);
        return (t == ENC_DATA) || (t == ENC_EOP) || (t == ENC_EEP);
    endfunction

endpackage

// File: rtl/tx_sched_pick.sv
// ----------------------------------------------------------------------------
// tx_sched_pick
//   Combinational priority selector for the next TX character.
//   Priority: TIME-CODE > FCT > N-Char > NULL, each gated by link_state and,
//   for N-Chars, by non-zero TX credit.
//   Ports:
//     tick_pend_i   pending time-code request
//     tick_val_i    value of the pending time-code
//     fct_req_i     RX side owes an FCT
//     txwrite_i     host N-Char valid
//     txdata_i      host N-Char (bit DATA_W = control flag)
//     tx_credit_i   remaining TX credit
//     link_state_i  0 STARTED, 1 CONNECTING, 2/3 RUN
//     pick_type_o   selected character type
//     pick_data_o   selected data byte / time-code (0 for other types)
// ----------------------------------------------------------------------------
module tx_sched_pick
    import tx_sched_pkg::*;
#(
    parameter int CREDIT_W = 6,
    parameter int DATA_W   = 8
) (
    input  logic                tick_pend_i,
    input  logic [7:0]          tick_val_i,
    input  logic                fct_req_i,
    input  logic                txwrite_i,
    input  logic [DATA_W:0]     txdata_i,
    input  logic [CREDIT_W-1:0] tx_credit_i,
    input  logic [1:0]          link_state_i,
    output enc_type_e           pick_type_o,
    output logic [7:0]          pick_data_o
);

    logic link_run;
    logic link_conn;
    logic ctrl_flag;
    logic [DATA_W-1:0] payload;

    assign link_run  = (link_state_i >= LINK_RUN);
    assign link_conn = (link_state_i >= LINK_CONNECTING);
    assign ctrl_flag = txdata_i[DATA_W];
    assign payload   = txdata_i[DATA_W-1:0];

    always_comb begin
        pick_type_o = ENC_NULL;
        pick_data_o = 8'h00;
        if (tick_pend_i && link_run) begin
            pick_type_o = ENC_TIMEC;
            pick_data_o = tick_val_i;
        end else if (fct_req_i && link_conn) begin
            pick_type_o = ENC_FCT;
        end else if (txwrite_i && (tx_credit_i != '0) && link_run) begin
            if (!ctrl_flag) begin
                pick_type_o = ENC_DATA;
                pick_data_o = 8'(payload);
            end else if (payload == DATA_W'(CTRL_EOP)) begin
                pick_type_o = ENC_EOP;
            end else begin
                // Any control byte other than EOP is sent as an error end.
                pick_type_o = ENC_EEP;
            end
        end
    end

endmodule

// File: rtl/tx_char_scheduler.sv
// ----------------------------------------------------------------------------
// tx_char_scheduler
//   Transmit-side character scheduler for a SpaceWire link. Each slot it picks
//   one character for the TX encoder (TIME-CODE > FCT > N-Char > NULL, gated by
//   link state and TX credit), holds it until the encoder takes it, then
//   inserts a one-cycle gap so the credit counter can see char_sent before the
//   next pick.
//
//   Optional feature macro: TX_SCHED_TIMECODE_EN
//     defined     : tick_in/time_in arm a pending time-code, sent as TIMEC.
//     not defined : tick_in/time_in ignored, TIMEC is never issued.
//
//   Ports:
//     pclk_tx     in   TX clock
//     reset_tx    in   synchronous active-high reset
//     enable_tx   in   link enable; low aborts like reset
//     link_state  in   0 STARTED, 1 CONNECTING, 2/3 RUN
//     tick_in     in   time-code request pulse
//     time_in     in   time-code value, sampled with tick_in
//     fct_req     in   RX buffer owes one FCT (level)
//     fct_ack     out  FCT handed to encoder this cycle
//     txwrite     in   host N-Char valid
//     txdata      in   host N-Char (bit DATA_W: control flag)
//     txrdy       out  host N-Char consumed this cycle
//     tx_credit   in   characters the host may still send
//     enc_ready   in   encoder accepts a character this cycle
//     enc_valid   out  character presented to encoder
//     enc_type    out  0 NULL,1 FCT,2 TIMEC,3 DATA,4 EOP,5 EEP
//     enc_data    out  data byte or time-code, 0 otherwise
//     char_sent   out  one pulse per N-Char transfer
//
//   Encoder handshake: a character moves when enc_valid and enc_ready are both
//   high at a rising pclk_tx edge. While enc_valid is high and enc_ready low,
//   enc_type/enc_data stay unchanged; enc_valid only falls after a transfer or
//   on abort (reset_tx high / enable_tx low).
// ----------------------------------------------------------------------------
module tx_char_scheduler
    import tx_sched_pkg::*;
#(
    parameter int CREDIT_W = 6,
    parameter int DATA_W   = 8
) (
    input  logic                pclk_tx,
    input  logic                reset_tx,
    input  logic                enable_tx,
    input  logic [1:0]          link_state,
    input  logic                tick_in,
    input  logic [7:0]          time_in,
    input  logic                fct_req,
    output logic                fct_ack,
    input  logic                txwrite,
    input  logic [DATA_W:0]     txdata,
    output logic                txrdy,
    input  logic [CREDIT_W-1:0] tx_credit,
    input  logic                enc_ready,
    output logic                enc_valid,
    output logic [2:0]          enc_type,
    output logic [7:0]          enc_data,
    output logic                char_sent
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    sched_state_e state_q;
    logic         valid_q;
    enc_type_e    type_q;
    logic [7:0]   data_q;

    logic         tick_pend_q;
    logic [7:0]   tick_val_q;

    logic         abort;
    logic         xfer;

    enc_type_e    pick_type;
    logic [7:0]   pick_data;

    // Reset and link disable share one path: everything returns to IDLE and
    // any held character is dropped without side effects.
    assign abort = reset_tx || !enable_tx;
    assign xfer  = valid_q && enc_ready && !abort;

    // ------------------------------------------------------------------
    // Pending time-code
    // ------------------------------------------------------------------
`ifdef TX_SCHED_TIMECODE_EN
    logic         tick_pend_d;
    logic [7:0]   tick_val_d;

    always_comb begin
        tick_pend_d = tick_pend_q;
        tick_val_d  = tick_val_q;
        if (xfer && (type_q == ENC_TIMEC)) begin
            tick_pend_d = 1'b0;
        end
        // A new tick wins over the clear, so a tick coinciding with a TIMEC
        // transfer re-arms with the new value. A tick while pending simply
        // overwrites the value.
        if (tick_in) begin
            tick_pend_d = 1'b1;
            tick_val_d  = time_in;
        end
    end

    always_ff @(posedge pclk_tx) begin
        if (abort) begin
            tick_pend_q <= 1'b0;
            tick_val_q  <= 8'h00;
        end else begin
            tick_pend_q <= tick_pend_d;
            tick_val_q  <= tick_val_d;
        end
    end
`else
    logic unused_tick;

    assign tick_pend_q = 1'b0;
    assign tick_val_q  = 8'h00;
    assign unused_tick = ^{tick_in, time_in};
`endif

    // ------------------------------------------------------------------
    // Priority selection
    // ------------------------------------------------------------------
    tx_sched_pick #(
        .CREDIT_W (CREDIT_W),
        .DATA_W   (DATA_W)
    ) u_pick (
        .tick_pend_i  (tick_pend_q),
        .tick_val_i   (tick_val_q),
        .fct_req_i    (fct_req),
        .txwrite_i    (txwrite),
        .txdata_i     (txdata),
        .tx_credit_i  (tx_credit),
        .link_state_i (link_state),
        .pick_type_o  (pick_type),
        .pick_data_o  (pick_data)
    );

    // ------------------------------------------------------------------
    // Slot FSM: IDLE (pick) -> HOLD (present) -> GAP -> IDLE
    // The selection is frozen in HOLD: later requests and link_state changes
    // only affect the next pick, because the encoder already owns the slot.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk_tx) begin
        if (abort) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            type_q  <= ENC_NULL;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_HOLD;
                    valid_q <= 1'b1;
                    type_q  <= pick_type;
                    data_q  <= pick_data;
                end
                ST_HOLD: begin
                    if (enc_ready) begin
                        state_q <= ST_GAP;
                        valid_q <= 1'b0;
                        type_q  <= ENC_NULL;
                        data_q  <= 8'h00;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    type_q  <= ENC_NULL;
                    data_q  <= 8'h00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign enc_valid = valid_q;
    assign enc_type  = type_q;
    assign enc_data  = data_q;

    // Side-effect pulses coincide with the transfer cycle itself so that the
    // host and the credit counter update on the same edge as the encoder.
    // They are masked during abort, so a dropped character leaves no trace.
    assign fct_ack   = xfer && (type_q == ENC_FCT);
    assign txrdy     = xfer && is_nchar(type_q);
    assign char_sent = xfer && is_nchar(type_q);

endmodule
